// File: rtl/zone_pump_scheduler_pkg.sv
// Shared types and defaults for the zone pump scheduler.
package zone_pump_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // 224 clk_fg cycles give a 1 s tick at the 224 Hz function-generator clock.
  localparam int DEFAULT_TICK_DIV = 224;

endpackage

// File: rtl/zone_pump_scheduler_tick_gen.sv
// Free-running tick divider that restarts from zero whenever clr_i is high.
module zone_pump_scheduler_tick_gen #(
  parameter int TICK_DIV = 224
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on request, wrap after the last cycle of a tick period.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/zone_pump_scheduler.sv
// Round-robin pump time-sharing across irrigation zones with bounded run
// window and a mandatory rest gap between grants.
module zone_pump_scheduler
  import zone_pump_scheduler_pkg::*;
#(
  parameter int N_ZONES  = 4,
  parameter int MAX_RUN  = 8,
  parameter int GAP      = 2,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic               clk_fg,
  input  logic               init_n,
  input  logic               enable_i,
  input  logic               abort_i,
  input  logic [N_ZONES-1:0] req_i,
  output logic [N_ZONES-1:0] grant_o,
  output logic               pump_on_o,
  output logic [2:0]         zone_o,
  output logic [3:0]         run_left_o,
  output logic               busy_o
);

  localparam logic [3:0] MAX_RUN_L = 4'(MAX_RUN);
  localparam logic [3:0] GAP_L     = 4'(GAP);
  localparam logic [2:0] LAST_INIT = 3'(N_ZONES - 1);

  function automatic logic [N_ZONES-1:0] onehot(input logic [2:0] idx);
    logic [N_ZONES-1:0] v;
    v = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      if (idx == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Returns {found, index}: first requester after 'last', wrapping around.
  function automatic logic [3:0] rr_select(input logic [N_ZONES-1:0] req,
                                           input logic [2:0]         last);
    logic [N_ZONES-1:0] sh;
    logic               found;
    logic [2:0]         idx;
    int                 c;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_ZONES; i++) begin
      c  = (int'(last) + i) % N_ZONES;
      sh = req >> c;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = 3'(c);
      end
    end
    return {found, idx};
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         zone_q, zone_d;
  logic [3:0]         run_left_q, run_left_d;
  logic [3:0]         gap_q, gap_d;
  logic [N_ZONES-1:0] grant_q, grant_d;
  logic               pump_q, pump_d;
  logic               busy_q, busy_d;
  logic               tick, tick_clr, abort_c, cur_req;
  logic [3:0]         sel;

  assign abort_c = abort_i | ~enable_i;
  assign sel     = rr_select(req_i, last_q);
  assign cur_req = |(req_i & onehot(last_q));

  zone_pump_scheduler_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_fg),
    .rst_ni (init_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Next-state, counters and registered output values; abort wins over all.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    run_left_d = run_left_q;
    gap_d      = gap_q;
    if (abort_c) begin
      state_d    = ST_GAP;
      gap_d      = GAP_L;
      run_left_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel[3]) begin
            state_d    = ST_RUN;
            last_d     = sel[2:0];
            run_left_d = MAX_RUN_L;
          end
        end
        ST_RUN: begin
          if (!cur_req || (tick && run_left_q == 4'd1)) begin
            state_d    = ST_GAP;
            gap_d      = GAP_L;
            run_left_d = '0;
          end else if (tick) begin
            run_left_d = run_left_q - 4'd1;
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (gap_q == 4'd1) begin
              state_d = ST_IDLE;
              gap_d   = '0;
            end else begin
              gap_d = gap_q - 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    grant_d  = (state_d == ST_RUN) ? onehot(last_d) : '0;
    zone_d   = (state_d == ST_RUN) ? last_d : 3'd0;
    pump_d   = (state_d == ST_RUN);
    busy_d   = (state_d != ST_IDLE);
    // Tick phase restarts on every state entry and while abort is held.
    tick_clr = abort_c || (state_d != state_q);
  end

  // State and output registers; reset clears outputs asynchronously.
  always_ff @(posedge clk_fg or negedge init_n) begin
    if (!init_n) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_INIT;
      zone_q     <= '0;
      run_left_q <= '0;
      gap_q      <= '0;
      grant_q    <= '0;
      pump_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      zone_q     <= zone_d;
      run_left_q <= run_left_d;
      gap_q      <= gap_d;
      grant_q    <= grant_d;
      pump_q     <= pump_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign pump_on_o  = pump_q;
  assign zone_o     = zone_q;
  assign run_left_o = run_left_q;
  assign busy_o     = busy_q;

endmodule
